spatz_vrf_banked: RTL and testbench
===================================

// Module: spatz_vrf_banked
// PURPOSE
// Banked vector register file answering the VFU's operand requests: NrReadPorts read ports
// (0=vs2, 1=vs1, 2=vd-as-source) plus one byte-enabled write port, each with a valid return.
// Words interleave across NrBanks banks. Each bank has one read and one write path per cycle.
// Read conflicts inside a bank are resolved by a per-bank round-robin pointer.
// PARAMETERS
// NrReadPorts      3                 number of read ports
// NrVRegs          32                architectural vector registers
// NrWordsPerVector spatz_pkg value   VRF words per vector register
// NrBanks          4                 power of two; bank = addr[$clog2(NrBanks)-1:0]
// DataWidth        N_IPU*ELEN        VRF word width; byte enables = DataWidth/8
// AddrWidth        $clog2(NrVRegs*NrWordsPerVector)  derived, not overridable
// PORTS
// clk_i     in   1                        clock
// rst_ni    in   1                        asynchronous active-low reset
// waddr_i   in   AddrWidth                write word address
// wdata_i   in   DataWidth                write data
// we_i      in   1                        write request
// wbe_i     in   DataWidth/8              write byte enables
// wvalid_o  out  1                        write accepted this cycle
// raddr_i   in   NrReadPorts x AddrWidth  read word addresses
// re_i      in   NrReadPorts              read requests
// rdata_o   out  NrReadPorts x DataWidth  read data, valid with rvalid_o
// rvalid_o  out  NrReadPorts              read granted this cycle
// BEHAVIOUR
// - One clock (clk_i); reset asynchronous, active-low (rst_ni). Reset clears all storage and
//   every bank pointer to 0. Outputs are combinational and read 0 while in reset.
// - Write: always accepted. wvalid_o = we_i, same cycle. Bytes with wbe_i=1 update at the
//   next rising edge. wbe_i=0 leaves the word unchanged but still asserts wvalid_o.
// - Read latency 0: rvalid_o[p] and rdata_o[p] are combinational from re_i/raddr_i and state.
// - Grants never depend on we_i (no we->grant->rvalid loop back into the VFU).
// - Bank arbitration: candidate ports are those with re_i[p]=1 targeting bank b.
//   - Grant goes to the first candidate at or after ptr_q[b], searching in increasing port
//     order and wrapping modulo NrReadPorts.
//   - Exception: ports reading the same address as the granted port are also granted
//     (same word, shared read).
//   - ptr_q[b] <= granted+1 (mod NrReadPorts) only when b had >=2 distinct-address candidates;
//     otherwise ptr_q[b] holds.
// - Ungranted ports: rvalid_o=0, rdata_o='0. The initiator holds re_i/raddr_i stable until
//   rvalid_o. Round robin guarantees a grant within NrReadPorts cycles.
// - Read and write to the same address in the same cycle: the read returns the pre-write
//   data (old value) unless forwarding is enabled.
// - Out-of-range addresses (>= NrVRegs*NrWordsPerVector when not a power of two): write
//   ignored, but wvalid_o still asserted; read returns '0, with rvalid_o per arbitration.
// - Reset asserted mid-access: storage and pointers clear immediately. A pending request
//   is re-arbitrated from ptr=0 after release.
// CONFIGURATION
// SPATZ_VRF_WRITE_FORWARD_EN defined: on a same-cycle same-address read and write, rdata_o
//   merges the data: wdata_i bytes where wbe_i=1, stored bytes elsewhere. Grants unaffected.
// Undefined: no forwarding; reads see old data and the write is visible from the next cycle.
// TESTING
// 1 Reset then read port0 addr 5 -> rvalid_o[0]=1 same cycle, rdata_o[0]=0.
// 2 Write addr 9 data 0xA5.. wbe all-1. Next cycle read ports 0/1 addr 9 -> both granted,
//   both return 0xA5.
// 3 Ports 0,1,2 read addrs 0,4,8 (all bank0, NrBanks=4) held 3 cycles
//   -> grants in order 0,1,2, one per cycle; ptr_q[0] ends at 0.
// 4 Write addr 3 wbe=0x0F data 0x11.., old 0x22.. and read addr 3 same cycle
//   -> without macro read 0x22..; with SPATZ_VRF_WRITE_FORWARD_EN low 4 bytes 0x11.
// 5 Ports 0/1 read addrs 1,2 (different banks), we_i=1 to addr 1
//   -> both granted, wvalid_o=1.
// 6 rst_ni low during a 3-way conflict -> outputs 0 and storage 0; after release, port0
//   granted first.

Source files
------------

// File: rtl/spatz_vrf_banked.sv
// spatz_vrf_banked: banked VRF with round-robin read arbitration per bank and one byte-enabled write port.
// Define SPATZ_VRF_WRITE_FORWARD_EN to forward same-cycle write data to a read of the same address.
module spatz_vrf_banked #(
    parameter int unsigned NrReadPorts      = 3,
    parameter int unsigned NrVRegs          = 32,
    parameter int unsigned NrWordsPerVector = 8,
    parameter int unsigned NrBanks          = 4,
    parameter int unsigned DataWidth        = 64,
    localparam int unsigned AddrWidth       = $clog2(NrVRegs * NrWordsPerVector)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [AddrWidth-1:0]                  waddr_i,
    input  logic [DataWidth-1:0]                  wdata_i,
    input  logic                                  we_i,
    input  logic [DataWidth/8-1:0]                wbe_i,
    output logic                                  wvalid_o,
    input  logic [NrReadPorts-1:0][AddrWidth-1:0] raddr_i,
    input  logic [NrReadPorts-1:0]                re_i,
    output logic [NrReadPorts-1:0][DataWidth-1:0] rdata_o,
    output logic [NrReadPorts-1:0]                rvalid_o
);
    localparam int unsigned NrWords  = NrVRegs * NrWordsPerVector;
    localparam int unsigned NrBytes  = DataWidth / 8;
    localparam int unsigned PtrWidth = NrReadPorts > 1 ? $clog2(NrReadPorts) : 1;

    logic [DataWidth-1:0]             mem_q [NrWords];
    logic [DataWidth-1:0]             wword_d;
    logic [NrBanks-1:0][PtrWidth-1:0] ptr_q, ptr_d, win;
    logic [NrBanks-1:0]               found, multi;
    logic [NrReadPorts-1:0]           gnt, fwd;
    logic                             w_ok;

    function automatic int bank_of(logic [AddrWidth-1:0] a);
        return int'(32'(a) % NrBanks);
    endfunction

    function automatic int port_at(logic [PtrWidth-1:0] ptr, int k);
        return (int'(ptr) + k) % int'(NrReadPorts);
    endfunction

    assign w_ok = 32'(waddr_i) < NrWords;

    // Merged word is both the write-back value and the forwarded read value.
    always_comb begin
        for (int i = 0; i < NrBytes; i++)
            wword_d[8*i +: 8] = wbe_i[i] ? wdata_i[8*i +: 8] : mem_q[waddr_i][8*i +: 8];
    end

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = '0;
        multi = '0;
        win   = '0;
        for (int b = 0; b < NrBanks; b++) begin
            for (int k = 0; k < NrReadPorts; k++)
                if (!found[b] && re_i[port_at(ptr_q[b], k)] && bank_of(raddr_i[port_at(ptr_q[b], k)]) == b) begin
                    found[b] = 1'b1;
                    win[b]   = PtrWidth'(port_at(ptr_q[b], k));
                end
            // Same-word readers share the grant; any other address makes it a real conflict.
            for (int p = 0; p < NrReadPorts; p++)
                if (found[b] && re_i[p] && bank_of(raddr_i[p]) == b) begin
                    if (raddr_i[p] == raddr_i[win[b]]) gnt[p] = 1'b1;
                    else multi[b] = 1'b1;
                end
            if (multi[b]) ptr_d[b] = PtrWidth'((int'(win[b]) + 1) % int'(NrReadPorts));
        end
    end

    always_comb begin
        for (int p = 0; p < NrReadPorts; p++) begin
`ifdef SPATZ_VRF_WRITE_FORWARD_EN
            fwd[p] = we_i && w_ok && raddr_i[p] == waddr_i;
`else
            fwd[p] = 1'b0;
`endif
            rvalid_o[p] = gnt[p] & rst_ni;
            rdata_o[p]  = !rvalid_o[p] || 32'(raddr_i[p]) >= NrWords ? '0 :
                          fwd[p] ? wword_d : mem_q[raddr_i[p]];
        end
    end

    assign wvalid_o = we_i & rst_ni;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < NrWords; w++) mem_q[w] <= '0;
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (we_i && w_ok) mem_q[waddr_i] <= wword_d;
        end
    end
endmodule

// File: tb/tb_spatz_vrf_banked.sv
// tb_spatz_vrf_banked: table-driven vectors with a scoreboard queue, plus a mid-conflict reset sequence.
module tb_spatz_vrf_banked;
    localparam int NP = 3, AW = 8, DW = 64, BW = 8;
`ifdef SPATZ_VRF_WRITE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [DW-1:0] A5 = 64'hA5A5A5A5A5A5A5A5, H22 = 64'h2222222222222222,
                              H11 = 64'h1111111111111111, H77 = 64'h7777777777777777,
                              H44 = 64'h4444444444444444, H88 = 64'h8888888888888888,
                              HC3 = 64'hC3C3C3C3C3C3C3C3, H5A = 64'h5A5A5A5A5A5A5A5A,
                              HFF = 64'hFFFFFFFFFFFFFFFF, MIX = 64'h2222222211111111;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic we, wvalid;
    logic [BW-1:0] wbe;
    logic [NP-1:0][AW-1:0] raddr;
    logic [NP-1:0] re, rvalid;
    logic [NP-1:0][DW-1:0] rdata;

    always #5 clk = ~clk;

    spatz_vrf_banked #(.NrReadPorts(NP), .NrVRegs(32), .NrWordsPerVector(8), .NrBanks(4), .DataWidth(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .wbe_i(wbe),
        .wvalid_o(wvalid), .raddr_i(raddr), .re_i(re), .rdata_o(rdata), .rvalid_o(rvalid));

    typedef struct {
        logic we; logic [AW-1:0] waddr; logic [DW-1:0] wdata; logic [BW-1:0] wbe;
        logic [NP-1:0] re; logic [NP-1:0][AW-1:0] raddr;
        logic ev; logic [NP-1:0] erv; logic [NP-1:0][DW-1:0] ed;
    } vec_t;
    typedef struct { string name; logic ev; logic [NP-1:0] erv; logic [NP-1:0][DW-1:0] ed; } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int checks = 0, errors = 0;

    function automatic vec_t mk(logic w, logic [AW-1:0] wa, logic [DW-1:0] wd, logic [BW-1:0] be,
                                logic [NP-1:0] r, logic [AW-1:0] a0, a1, a2,
                                logic ev, logic [NP-1:0] erv, logic [DW-1:0] d0, d1, d2);
        vec_t v;
        v.we = w; v.waddr = wa; v.wdata = wd; v.wbe = be; v.re = r; v.raddr = {a2, a1, a0};
        v.ev = ev; v.erv = erv; v.ed = {d2, d1, d0};
        return v;
    endfunction

    function automatic void chk(string n, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endfunction

    task automatic drive(vec_t v, string n);
        exp_t e;
        we = v.we; waddr = v.waddr; wdata = v.wdata; wbe = v.wbe; re = v.re; raddr = v.raddr;
        e.name = n; e.ev = v.ev; e.erv = v.erv; e.ed = v.ed;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard empty got 0 entries want 1");
            return;
        end
        checks--;
        e = sb.pop_front();
        chk({e.name, ".wvalid"}, DW'(wvalid), DW'(e.ev));
        chk({e.name, ".rvalid"}, DW'(rvalid), DW'(e.erv));
        for (int p = 0; p < NP; p++) chk($sformatf("%s.rdata%0d", e.name, p), rdata[p], e.ed[p]);
    endtask

    initial begin
        // basic read/write, partial write, bank independence
        vecs.push_back(mk(0, 0, 0, 0, 3'b001, 5, 0, 0, 0, 3'b001, 0, 0, 0));
        vecs.push_back(mk(1, 9, A5, 8'hFF, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3'b011, 9, 9, 0, 0, 3'b011, A5, A5, 0));
        vecs.push_back(mk(1, 3, H22, 8'hFF, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0));
        vecs.push_back(mk(1, 3, H11, 8'h0F, 3'b001, 3, 0, 0, 1, 3'b001, FWD ? MIX : H22, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3'b001, 3, 0, 0, 0, 3'b001, MIX, 0, 0));
        vecs.push_back(mk(1, 1, H77, 8'hFF, 3'b011, 1, 2, 0, 1, 3'b011, FWD ? H77 : 0, 0, 0));
        vecs.push_back(mk(1, 1, HFF, 8'h00, 3'b001, 1, 0, 0, 1, 3'b001, H77, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3'b001, 1, 0, 0, 0, 3'b001, H77, 0, 0));
        vecs.push_back(mk(1, 4, H44, 8'hFF, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0));
        vecs.push_back(mk(1, 8, H88, 8'hFF, 3'b000, 0, 0, 0, 1, 3'b000, 0, 0, 0));
        // three-way bank0 conflict held: round robin 0,1,2 then back to 0
        vecs.push_back(mk(0, 0, 0, 0, 3'b111, 0, 4, 8, 0, 3'b001, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3'b111, 0, 4, 8, 0, 3'b010, 0, H44, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3'b111, 0, 4, 8, 0, 3'b100, 0, 0, H88));
        vecs.push_back(mk(0, 0, 0, 0, 3'b111, 0, 4, 8, 0, 3'b001, 0, 0, 0));
        // shared-address grant alongside a conflict; write does not disturb grants
        vecs.push_back(mk(1, 0, HC3, 8'hFF, 3'b111, 0, 4, 0, 1, 3'b010, 0, H44, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3'b111, 0, 4, 0, 0, 3'b101, HC3, 0, HC3));
        vecs.push_back(mk(0, 0, 0, 0, 3'b110, 0, 4, 5, 0, 3'b110, 0, H44, 0));

        we = 0; waddr = 0; wdata = 0; wbe = 0; re = 0; raddr = '0;
        @(posedge clk); #1;
        drive(mk(1, 9, A5, 8'hFF, 3'b001, 5, 0, 0, 0, 3'b000, 0, 0, 0), "in_reset");
        @(negedge clk); check();
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            drive(vecs[i], $sformatf("row%0d", i));
            @(negedge clk); check();
        end

        // reset during a conflict after the pointer has advanced
        @(posedge clk); #1;
        drive(mk(1, 9, H5A, 8'hFF, 3'b111, 4, 0, 8, 1, 3'b001, H44, 0, 0), "pre_rst");
        @(negedge clk); check();
        @(posedge clk); #1 rst_n = 1'b0;
        drive(mk(1, 9, H5A, 8'hFF, 3'b111, 4, 0, 8, 0, 3'b000, 0, 0, 0), "mid_rst");
        @(negedge clk); check();
        @(posedge clk); #1 rst_n = 1'b1;
        drive(mk(0, 0, 0, 0, 3'b111, 4, 0, 8, 0, 3'b001, 0, 0, 0), "post_rst");
        @(negedge clk); check();
        @(posedge clk); #1;
        drive(mk(0, 0, 0, 0, 3'b001, 9, 0, 0, 0, 3'b001, 0, 0, 0), "cleared");
        @(negedge clk); check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
